// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32I register-register execute unit.
// Single-cycle ops complete in IDLE; shifts iterate one bit per cycle.
// Optional iterative shift-add multiplier built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            cout,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned CntW = SHW + 1;
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b0001;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b1101;
    localparam logic [3:0] OpOr   = 4'b0110;
    localparam logic [3:0] OpAnd  = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OpMul  = 4'b1001;
    localparam logic [CntW-1:0] MulIters = CntW'(XLEN);
`endif

    typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cout_q, cout_d;
    logic            illegal_q, illegal_d;
    logic            done_q, done_d;

    logic            sub_sel;
    logic [XLEN:0]   add_ext;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] shifted;

`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] acc_sum;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    // SUB is a + ~b + 1 so cout reads as "no borrow".
    assign sub_sel = (op == OpSub);
    assign add_ext = {1'b0, a} + {1'b0, (sub_sel ? ~b : b)} + {{XLEN{1'b0}}, sub_sel};
    assign shamt   = b[SHW-1:0];

    // One-bit shift step of the working register; SRA keeps the original sign bit.
    always_comb begin
        shifted = work_q;
        case (op_q)
            OpSll:   shifted = {work_q[XLEN-2:0], 1'b0};
            OpSrl:   shifted = {1'b0, work_q[XLEN-1:1]};
            default: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    // Next-state, datapath updates and result write-back.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        cout_d    = cout_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    cout_d    = 1'b0;
                    illegal_d = 1'b0;
                    case (op)
                        OpAdd, OpSub: begin
                            result_d = add_ext[XLEN-1:0];
                            cout_d   = add_ext[XLEN];
                            done_d   = 1'b1;
                        end
                        OpSlt: begin
                            result_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                            done_d   = 1'b1;
                        end
                        OpSltu: begin
                            result_d = {{(XLEN-1){1'b0}}, (a < b)};
                            done_d   = 1'b1;
                        end
                        OpXor: begin
                            result_d = a ^ b;
                            done_d   = 1'b1;
                        end
                        OpOr: begin
                            result_d = a | b;
                            done_d   = 1'b1;
                        end
                        OpAnd: begin
                            result_d = a & b;
                            done_d   = 1'b1;
                        end
                        OpSll, OpSrl, OpSra: begin
                            if (shamt == '0) begin
                                result_d = a;
                                done_d   = 1'b1;
                            end else begin
                                work_d  = a;
                                cnt_d   = {1'b0, shamt};
                                state_d = StShift;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OpMul: begin
                            mcand_d  = a;
                            mplier_d = b;
                            acc_d    = '0;
                            cnt_d    = MulIters;
                            state_d  = StMul;
                        end
`endif
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            StShift: begin
                work_d = shifted;
                cnt_d  = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    result_d = shifted;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                cnt_d    = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    result_d = acc_sum;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any in-flight op.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            work_q    <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Multiplier operand and accumulator registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
`endif

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign zero    = (result_q == '0);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model expectations, monitor checks on done.
module tb_alu_seq;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [3:0]      op    = 4'b0;
    logic [XLEN-1:0] a     = '0;
    logic [XLEN-1:0] b     = '0;
    logic            busy, done, cout, zero, illegal;
    logic [XLEN-1:0] result;

    alu_seq #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0] r;
        logic            c;
        logic            ill;
        int              at_edge;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour straight from the op table; lat = edges from accept to done.
    task automatic model(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         output logic [XLEN-1:0] r, output logic c, output logic ill,
                         output int lat);
        logic [XLEN:0] s;
        int k;
        k   = int'(y[SHW-1:0]);
        r   = '0;
        c   = 1'b0;
        ill = 1'b0;
        lat = 0;
        case (o)
            4'b0000: begin s = {1'b0, x} + {1'b0, y}; r = x + y; c = s[XLEN]; end
            4'b1000: begin r = x - y; c = (x >= y); end
            4'b0001: begin r = x << k; lat = k; end
            4'b0010: r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'b0011: r = (x < y) ? 1 : 0;
            4'b0100: r = x ^ y;
            4'b0101: begin r = x >> k; lat = k; end
            4'b1101: begin r = $signed(x) >>> k; lat = k; end
            4'b0110: r = x | y;
            4'b0111: r = x & y;
`ifdef ALU_SEQ_MUL_EN
            4'b1001: begin r = x * y; lat = XLEN; end
`endif
            default: ill = 1'b1;
        endcase
    endtask

    // Waits for idle, presents one request and records its expected outcome.
    task automatic issue(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        exp_t e;
        int lat;
        int w;
        w = 0;
        while (busy && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (busy) chk("issue_wait_timeout", 1, 0);
        model(o, x, y, e.r, e.c, e.ill, lat);
        e.at_edge = cyc + 1 + lat;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        if (lat == 0) chk("single_cycle_busy", {31'b0, busy}, 0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    // Monitor: checks every done against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (done && busy) chk("done_and_busy", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.r);
                    chk("cout", {31'b0, cout}, {31'b0, e.c});
                    chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
                    chk("zero", {31'b0, zero}, {31'b0, (e.r == '0)});
                    chk("done_edge", cyc, e.at_edge);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ro;
        logic [XLEN-1:0] ra, rb;

        // Reset values
        #3;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", {31'b0, zero}, 1);
        chk("rst_illegal", {31'b0, illegal}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases, back-to-back where single-cycle
        issue(4'b0000, 32'hFFFF_FFFF, 32'h1);
        issue(4'b1000, 32'd5, 32'd7);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
        issue(4'b0001, 32'd1, 32'h20);
        issue(4'b1111, 32'h1234, 32'h5678);
        issue(4'b0110, 32'h00F0, 32'h0F00);
        drain();

        // Long SRA with an ADD start pulsed mid-shift that must be ignored
        issue(4'b1101, 32'h8000_0000, 32'd31);
        repeat (5) @(negedge clock);
        chk("busy_mid_shift", {31'b0, busy}, 1);
        start = 1'b1;
        op    = 4'b0000;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clock);
        start = 1'b0;
        drain();

        issue(4'b1001, 32'h0001_2345, 32'h0000_1000);
        drain();

        // Asynchronous reset during a 31-bit shift
        start = 1'b1;
        op    = 4'b0101;
        a     = 32'hDEAD_BEEF;
        b     = 32'd31;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_done", {31'b0, done}, 0);
        chk("arst_result", result, 0);
        chk("arst_zero", {31'b0, zero}, 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(4'b0000, 32'd2, 32'd3);
        drain();

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            issue(ro, ra, rb);
            if ($urandom_range(0, 4) == 0) @(negedge clock);
        end
        drain();
        repeat (40) @(negedge clock);
        chk("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
